// File: rtl/shift_pkg.sv
// Shared constants and the response record for the shifter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int ID_W    = 2;
    localparam int MAX_REQ = 4;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/shift_arbiter_leftshifter.sv
// Combinational 32-bit barrel left shifter, zero fill, result truncated.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module shift_arbiter_leftshifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  y
);

    // One stage per shift-amount bit, each shifting by a power of two.
    always_comb begin
        y = a;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (shamt[s]) y = y << (1 << s);
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter among NREQ (2..4) requesters.
// Latency: accept in cycle N gives resp_valid with data in cycle N+1.
// Backpressure: held response with resp_ready low blocks all req_ready.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [DATA_W*NREQ-1:0]    req_a,
    input  logic [SHAMT_W*NREQ-1:0]   req_shamt,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id
);

    logic [ID_W-1:0]    ptr;
    resp_t              resp_q;
    logic [NREQ-1:0]    grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               found;
    logic               can_issue;
    logic               accept;
    logic [DATA_W-1:0]  sel_a;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [DATA_W-1:0]  shift_y;

    // Scan positions ptr, ptr+1, ... modulo NREQ; first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] &&
                    ((int'(ptr) + k == i) || (int'(ptr) + k == i + NREQ))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_idx  = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_shamt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a     = req_a[i*DATA_W +: DATA_W];
                sel_shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
            end
        end
    end

    assign can_issue = !resp_valid || resp_ready;
    assign req_ready = (can_issue && !reset) ? grant : '0;
    assign accept    = |req_ready;

    shift_arbiter_leftshifter u_shifter (
        .a     (sel_a),
        .shamt (sel_shamt),
        .y     (shift_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_q     <= '0;
            ptr        <= '0;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_q.id   <= gnt_idx;
            resp_q.data <= shift_y;
            ptr         <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign resp_data = resp_q.data;
    assign resp_id   = resp_q.id;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single combinational 32-bit barrel left shifter among up to four requesters, such as the ALU shift path, the multiplier/divider sequencer and the address-generation unit. Arbitration is round-robin with per-requester valid/ready handshakes. One request is issued per cycle into the shifter, and the result is returned through a one-entry registered response port tagged with the requester ID. The block sits between the execute-stage requesters and the shifter core and holds the shifter's only pipeline register.

## Interface
- NREQ, 2: number of requesters, legal range 2–4.
- clock  in  1: rising-edge clock.
- reset  in  1: synchronous, active-high reset.
- req_valid  in  NREQ: request i is presented.
- req_ready  out  NREQ: request i is accepted this cycle.
- req_a  in  32*NREQ: operand of requester i, in bits [32i+31:32i].
- req_shamt  in  5*NREQ: shift amount of requester i, in bits [5i+4:5i].
- resp_valid  out  1: response register holds a result.
- resp_ready  in  1: consumer takes the result this cycle.
- resp_data  out  32: the value req_a << req_shamt, zero-filled, truncated to 32 bits.
- resp_id  out  2: index of the requester that produced resp_data.

## Operation
- State is held in the response register, `full` = resp_valid.
  - EMPTY → FULL on accept.
  - FULL → EMPTY on resp_ready when there is no accept.
  - FULL → FULL on resp_ready together with an accept, which gives back-to-back results.
- `can_issue` = !resp_valid || resp_ready.
- Round-robin pointer `ptr`, width 2, reset to 0.
  - Grant goes to the first i with req_valid[i] in the order ptr, ptr+1, …, wrapping modulo NREQ.
  - Grant is one-hot or zero.
- req_ready[i] = grant[i] && can_issue.
  - Combinational from req_valid, ptr, resp_valid and resp_ready.
  - At most one bit is set.
- Accept occurs when req_valid[i] && req_ready[i]. On accept:
  - resp_data ← shifter(req_a[i], req_shamt[i]).
  - resp_id ← i.
  - resp_valid ← 1.
  - ptr ← (i+1) mod NREQ.
- The pointer advances only on accept. Stalls (can_issue = 0) do not move it.
- Requesters must hold req_a and req_shamt stable while req_valid is high and unaccepted. The block does not latch unaccepted requests.
- shamt = 0 returns req_a unchanged. shamt = 31 returns {req_a[0], 31'b0}.
- Inputs for indices ≥ NREQ do not exist. The pointer never reaches an index ≥ NREQ.
- Fairness: a continuously valid requester is granted within NREQ accepts.

## Timing
- Latency: an accept in cycle N produces resp_valid = 1 with the data in cycle N+1.
- Throughput: one result per cycle while resp_ready = 1.
- Backpressure: while resp_valid && !resp_ready:
  - all req_ready bits are 0;
  - resp_data and resp_id hold stable.
- Reset (synchronous, takes effect at the edge where reset = 1):
  - resp_valid = 0, resp_data = 0, resp_id = 0, ptr = 0.
  - A held result is discarded.
  - req_ready is 0 during the reset cycle.
- Simultaneous requests: exactly one is granted. The others see req_ready = 0 and must keep waiting.
- req_valid dropping without an accept is legal and has no effect.
- resp_ready asserted while resp_valid = 0 is ignored.

## Structure
- Shared package shift_pkg holds the constants DATA_W = 32, SHAMT_W = 5, ID_W = 2 and MAX_REQ = 4.
- Sub-module: the existing combinational leftshifter (32-bit operand, 5-bit shift amount), instantiated once on the granted operand.
- Arbiter logic lives inline: the round-robin priority mux and the operand select mux.
- The response register and pointer are the only flops.

## Test plan
- Single request: reset, then req 0 with a = 0x0000_0001, shamt = 4, resp_ready = 1 → next cycle resp_valid = 1, resp_data = 0x0000_0010, resp_id = 0.
- Contention, NREQ = 3, all valid every cycle, resp_ready = 1 → grant order 0, 1, 2, 0, 1, 2; one result per cycle with matching resp_id.
- Backpressure: result pending, resp_ready = 0 for 3 cycles with req 1 valid → req_ready = 0 throughout, resp_data stable. On resp_ready = 1, req 1 is accepted the same cycle and its result appears the next cycle.
- Shift boundaries: a = 0x8000_0001 with shamt 0 → 0x8000_0001; shamt 1 → 0x0000_0002; shamt 31 → 0x8000_0000; a = 0xFFFF_FFFF with shamt 16 → 0xFFFF_0000.
- Reset mid-operation: resp_valid = 1 with the pointer at 2, assert reset for 1 cycle → resp_valid = 0, resp_data = 0, resp_id = 0; next with requests 1 and 2 both valid, requester 1 is granted first.
- Random check: 10k random requests, valid patterns and resp_ready → each result equals (a << shamt) & 0xFFFF_FFFF, no request lost or duplicated, and no requester waits more than NREQ accepts.
